// File: rtl/key_pkg.sv
// key_pkg: shared codes, row/column patterns and row decode for the key matrix scanner
package key_pkg;
  localparam logic [4:0] KEY_NONE = 5'd0;
  localparam logic [4:0] KEY_COMBO_BASE = 5'd21;
  localparam logic [4:0] KEY_DUAL = 5'd25;
  localparam logic [4:0] KEY_INVALID = 5'd31;
  localparam logic [4:0] ROW_IDLE = 5'b11111;
  localparam logic [4:0] ROW_COMBO = 5'b01110;
  localparam logic [3:0] COL0 = 4'b1110;
  localparam logic [3:0] COL1 = 4'b1101;
  localparam logic [3:0] COL2 = 4'b1011;
  localparam logic [3:0] COL3 = 4'b0111;
  // KEY_INVALID marks a column whose row pattern maps to no key
  function automatic logic [4:0] row_decode(input logic [1:0] c, input logic [4:0] r);
    logic [4:0] code;
    code = KEY_INVALID;
    if (r == ROW_IDLE) code = KEY_NONE;
    else if (r == ROW_COMBO) code = KEY_COMBO_BASE + {3'b000, c};
    else
      for (int k = 0; k < 5; k++)
        if (r == ~(5'b00001 << k)) code = 5'(32'(c) * 5 + k + 1);
    return code;
  endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: accepts a frame code after DEBOUNCE_CNT identical frames, strobes new nonzero codes
module key_debounce
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] frame_code,
  input  logic       frame_stb,
  output logic [4:0] key_code,
  output logic       key_valid,
  output logic       key_held
);
  localparam logic [3:0] CNT_MAX = 4'(DEBOUNCE_CNT);
  logic [3:0] stable_cnt_q, stable_cnt_d;
  logic [4:0] prev_q, prev_d, code_q, code_d;
  logic valid_q, valid_d;
  always_comb begin
    stable_cnt_d = stable_cnt_q;
    prev_d = prev_q;
    code_d = code_q;
    valid_d = 1'b0;
    if (frame_stb) begin
      stable_cnt_d = frame_code != prev_q ? 4'd1 : stable_cnt_q == CNT_MAX ? CNT_MAX : stable_cnt_q + 4'd1;
      prev_d = frame_code;
      if (stable_cnt_d == CNT_MAX && frame_code != code_q) begin
        code_d = frame_code;
        valid_d = frame_code != KEY_NONE;
      end
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      stable_cnt_q <= 4'd0;
      prev_q <= KEY_NONE;
      code_q <= KEY_NONE;
      valid_q <= 1'b0;
    end else begin
      stable_cnt_q <= stable_cnt_d;
      prev_q <= prev_d;
      code_q <= code_d;
      valid_q <= valid_d;
    end
  assign key_code = code_q;
  assign key_valid = valid_q;
  assign key_held = code_q != KEY_NONE;
endmodule

// File: rtl/key_matrix_scan.sv
// key_matrix_scan: scans a 4x5 key pad column by column and decodes one debounced key code per frame
module key_matrix_scan
  import key_pkg::*;
#(
  parameter int SCAN_DIV = 10000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] key_column_out,
  input  logic [4:0] key_row_in,
  output logic [4:0] key_code,
  output logic       key_valid,
  output logic       key_held
);
  localparam int SW = $clog2(SCAN_DIV);
  logic [SW-1:0] slot_q, slot_d;
  logic [1:0] col_q, col_d;
  logic [3:0] col_out_q, col_out_d;
  logic [4:0] code_q [3];
  logic [4:0] code_d [3];
  logic [4:0] all_codes [4];
  logic [4:0] cur_code, frame_code, sel_code;
  logic [2:0] n_active;
  logic last_slot, frame_stb, any_invalid;
  always_comb begin
    last_slot = slot_q == SW'(SCAN_DIV - 1);
    slot_d = last_slot ? '0 : slot_q + 1'b1;
    col_d = last_slot ? col_q + 2'd1 : col_q;
    col_out_d = col_d == 2'd0 ? COL0 : col_d == 2'd1 ? COL1 : col_d == 2'd2 ? COL2 : COL3;
    cur_code = row_decode(col_q, key_row_in);
    frame_stb = last_slot && col_q == 2'd3;
    code_d = code_q;
    for (int i = 0; i < 3; i++)
      if (last_slot && col_q == 2'(i)) code_d[i] = cur_code;
  end
  // column 3 is classified live on its sample cycle, so the frame resolves without an extra stage
  always_comb begin
    all_codes = '{code_q[0], code_q[1], code_q[2], cur_code};
    n_active = 3'd0;
    any_invalid = 1'b0;
    sel_code = KEY_NONE;
    for (int i = 0; i < 4; i++) begin
      if (all_codes[i] != KEY_NONE) begin
        n_active = n_active + 3'd1;
        sel_code = all_codes[i];
      end
      if (all_codes[i] == KEY_INVALID) any_invalid = 1'b1;
    end
    frame_code = n_active == 3'd1 && !any_invalid ? sel_code :
                 all_codes[0] == 5'd1 && all_codes[1] == 5'd6 &&
                 all_codes[2] == KEY_NONE && all_codes[3] == KEY_NONE ? KEY_DUAL : KEY_NONE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      slot_q <= '0;
      col_q <= 2'd0;
      col_out_q <= COL0;
      code_q <= '{default: KEY_NONE};
    end else begin
      slot_q <= slot_d;
      col_q <= col_d;
      col_out_q <= col_out_d;
      code_q <= code_d;
    end
  assign key_column_out = col_out_q;
  key_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_debounce (
    .clk(clk),
    .rst(rst),
    .frame_code(frame_code),
    .frame_stb(frame_stb),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_held(key_held)
  );
endmodule

// File: tb/tb_key_matrix_scan.sv
// tb_key_matrix_scan: key pad model plus scoreboard of expected key_valid codes
module tb_key_matrix_scan;
  localparam int FRAME = 16;
  localparam int WAIT = 3 * FRAME + 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] key_column_out;
  logic [4:0] key_row_in;
  logic [4:0] key_code;
  logic key_valid, key_held;
  logic [3:0] exp_col;
  int key_v = 0;
  int n_chk = 0;
  int n_pass = 0;
  logic [4:0] exp_q [$];
  always #5 clk = ~clk;
  key_matrix_scan #(.SCAN_DIV(4), .DEBOUNCE_CNT(2)) dut (
    .clk(clk),
    .rst(rst),
    .key_column_out(key_column_out),
    .key_row_in(key_row_in),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_held(key_held)
  );
  function automatic logic [4:0] pad_rows(input logic [3:0] col, input int kv);
    logic [4:0] rows;
    rows = 5'b11111;
    if (kv >= 1 && kv <= 20) begin
      if (!col[(kv - 1) / 5]) rows[(kv - 1) % 5] = 1'b0;
    end else if (kv >= 21 && kv <= 24) begin
      if (!col[kv - 21]) rows = 5'b01110;
    end else if (kv == 25) begin
      if (!col[0] || !col[1]) rows[0] = 1'b0;
    end
    return rows;
  endfunction
  always @(posedge clk) key_row_in <= pad_rows(key_column_out, key_v);
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask
  always @(negedge clk)
    if (key_valid) begin
      if (exp_q.size() == 0) check("spurious_valid", 32'(key_valid), 0);
      else check("valid_code", 32'(key_code), 32'(exp_q.pop_front()));
    end
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic press(input int kv, input bit expect_pulse);
    key_v = kv;
    if (expect_pulse) exp_q.push_back(5'(kv));
  endtask
  initial begin
    cycles(3);
    check("rst_col", 32'(key_column_out), 32'(4'b1110));
    check("rst_code", 32'(key_code), 0);
    check("rst_valid", 32'(key_valid), 0);
    check("rst_held", 32'(key_held), 0);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_col = ~(4'b0001 << ((i / 4) % 4));
      check("col_seq", 32'(key_column_out), 32'(exp_col));
      @(negedge clk);
    end
    press(13, 1);
    cycles(WAIT);
    check("single_pending", 32'(exp_q.size()), 0);
    check("single_code", 32'(key_code), 13);
    check("single_held", 32'(key_held), 1);
    cycles(2 * FRAME);
    check("single_hold_code", 32'(key_code), 13);
    check("single_hold_held", 32'(key_held), 1);
    press(0, 0);
    cycles(WAIT);
    check("release_code", 32'(key_code), 0);
    check("release_held", 32'(key_held), 0);
    press(24, 1);
    cycles(WAIT);
    check("combo_pending", 32'(exp_q.size()), 0);
    check("combo_code", 32'(key_code), 24);
    press(25, 1);
    cycles(WAIT);
    check("dual_pending", 32'(exp_q.size()), 0);
    check("dual_code", 32'(key_code), 25);
    press(0, 0);
    cycles(WAIT);
    check("dual_release", 32'(key_code), 0);
    for (int i = 0; i < 6; i++) begin
      press(i % 2 == 0 ? 7 : 0, 0);
      cycles(FRAME);
    end
    check("bounce_code", 32'(key_code), 0);
    press(7, 1);
    cycles(WAIT);
    check("bounce_pending", 32'(exp_q.size()), 0);
    check("bounce_code_final", 32'(key_code), 7);
    press(0, 0);
    cycles(WAIT);
    check("bounce_release", 32'(key_code), 0);
    press(30, 0);
    cycles(WAIT);
    check("oor_code", 32'(key_code), 0);
    check("oor_held", 32'(key_held), 0);
    press(3, 1);
    cycles(WAIT);
    check("pre_rst_pending", 32'(exp_q.size()), 0);
    check("pre_rst_code", 32'(key_code), 3);
    rst = 1'b0;
    #1;
    check("mid_rst_code", 32'(key_code), 0);
    check("mid_rst_held", 32'(key_held), 0);
    check("mid_rst_col", 32'(key_column_out), 32'(4'b1110));
    cycles(2);
    rst = 1'b1;
    exp_q.push_back(5'd3);
    cycles(FRAME + 4);
    check("rearm_early", 32'(key_code), 0);
    cycles(WAIT - FRAME - 4);
    check("rearm_pending", 32'(exp_q.size()), 0);
    check("rearm_code", 32'(key_code), 3);
    check("final_pending", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
